// File: rtl/carry_acc_stage.sv
// carry_acc_stage: word-serial chunked accumulator that retires one radix digit per iteration
module carry_acc_stage #(
    parameter int Size  = 3072,
    parameter int radix = 78,
    parameter int W     = 394,
    localparam int L    = Size + radix + 2,
    localparam int NCH  = L / W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [L-1:0]     r0,
    input  logic [L-1:0]     r1,
    input  logic             first,
    input  logic             last,
    output logic [radix-1:0] digit_out,
    output logic             digit_valid,
    output logic [L-1:0]     acc_out,
    output logic             done,
    output logic             busy,
    output logic             drop_err,
    output logic             ovf_err
);
    localparam int KW = $clog2(NCH);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT} state_t;

    state_t         state, nxt;
    logic [KW-1:0]  k;
    logic [1:0]     carry;
    logic [L-1:0]   acc, sum;
    logic [L-1:0]   cr0, cr1, pr0, pr1;
    logic           cfirst, clast, pfirst, plast, pvalid;
    logic [W+1:0]   s;
    logic           last_k, drain, en_pend, pend_load, drop, start;

    // One chunk of the three-operand add; a first iteration ignores the old accumulator
    always_comb begin
        s = (cfirst ? '0 : {2'b0, acc[k*W +: W]}) + {2'b0, cr0[k*W +: W]}
            + {2'b0, cr1[k*W +: W]} + {{W{1'b0}}, carry};
        last_k = k == KW'(NCH - 1);
        // A waiting strobe is moved into the capture regs whenever the adder is not mid-iteration
        drain = pvalid && state != ADD;
        en_pend = en && (state != IDLE || pvalid);
        pend_load = en_pend && (!pvalid || drain);
        drop = en_pend && pvalid && !drain;
        start = (state == IDLE && (en || pvalid)) || (state == SHIFT && pvalid);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    // Next-state: NCH add cycles then a single shift cycle, chaining straight into pending work
    always_comb begin
        nxt = state == IDLE  ? ((en || pvalid) ? ADD : IDLE) :
              state == ADD   ? (last_k ? SHIFT : ADD) :
              state == SHIFT ? (pvalid ? ADD : IDLE) : IDLE;
    end

    // Outputs derived from state
    always_comb begin
        busy = state != IDLE;
    end

    // Datapath: capture/pending buffers, chunked add, digit retirement and sticky errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k           <= '0;
            carry       <= '0;
            acc         <= '0;
            sum         <= '0;
            cr0         <= '0;
            cr1         <= '0;
            cfirst      <= 1'b0;
            clast       <= 1'b0;
            pr0         <= '0;
            pr1         <= '0;
            pfirst      <= 1'b0;
            plast       <= 1'b0;
            pvalid      <= 1'b0;
            digit_out   <= '0;
            digit_valid <= 1'b0;
            acc_out     <= '0;
            done        <= 1'b0;
            drop_err    <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            digit_valid <= 1'b0;
            done        <= 1'b0;
            if (pend_load) begin
                pr0    <= r0;
                pr1    <= r1;
                pfirst <= first;
                plast  <= last;
                pvalid <= 1'b1;
            end else if (drain) begin
                pvalid <= 1'b0;
            end
            if (drop) drop_err <= 1'b1;
            if (start) begin
                cr0    <= pvalid ? pr0 : r0;
                cr1    <= pvalid ? pr1 : r1;
                cfirst <= pvalid ? pfirst : first;
                clast  <= pvalid ? plast : last;
                k      <= '0;
                carry  <= '0;
            end
            if (state == ADD) begin
                sum[k*W +: W] <= s[W-1:0];
                carry         <= s[W+1:W];
                k             <= k + 1'b1;
                if (last_k && s[W+1:W] != 2'b0) ovf_err <= 1'b1;
            end
            if (state == SHIFT) begin
                digit_out   <= sum[radix-1:0];
                digit_valid <= 1'b1;
                acc         <= clast ? '0 : sum >> radix;
                if (clast) begin
                    acc_out <= sum >> radix;
                    done    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_carry_acc_stage.sv
// tb_carry_acc_stage: directed scoreboard bench for carry_acc_stage
module tb_carry_acc_stage;
    localparam int Size  = 3072;
    localparam int RADIX = 78;
    localparam int W     = 394;
    localparam int L     = Size + RADIX + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             first = 1'b0;
    logic             last = 1'b0;
    logic [L-1:0]     r0 = '0;
    logic [L-1:0]     r1 = '0;
    logic [RADIX-1:0] digit_out;
    logic             digit_valid;
    logic [L-1:0]     acc_out;
    logic             done, busy, drop_err, ovf_err;

    carry_acc_stage #(.Size(Size), .radix(RADIX), .W(W)) dut (
        .clk(clk), .rst(rst), .en(en), .r0(r0), .r1(r1), .first(first), .last(last),
        .digit_out(digit_out), .digit_valid(digit_valid), .acc_out(acc_out),
        .done(done), .busy(busy), .drop_err(drop_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total = 0;

    task automatic chk(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got top=%h low=%h, want top=%h low=%h",
                      name, act[L-1 -: 32], act[95:0], exp[L-1 -: 32], exp[95:0]);
    endtask

    typedef struct {
        logic [L-1:0] d;
        logic         dn;
        logic [L-1:0] a;
    } exp_t;

    exp_t sb[$];
    int   dvq[$];
    exp_t e;

    task automatic push(input logic [L-1:0] d, input logic dn, input logic [L-1:0] a);
        exp_t x;
        x.d = d;
        x.dn = dn;
        x.a = a;
        sb.push_back(x);
    endtask

    // Monitor: every retired digit is matched against the oldest expected response
    always @(negedge clk) begin
        if (digit_valid) begin
            dvq.push_back(cyc);
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_digit: got digit %h, want no digit", digit_out);
            end else begin
                e = sb.pop_front();
                chk("digit", L'(digit_out), e.d);
                chk("done", L'(done), L'(e.dn));
                if (e.dn) chk("acc_out", acc_out, e.a);
            end
        end
    end

    logic [L-1:0] vr0[4], vr1[4];
    logic         vf[4], vl[4];
    int           voff[4];
    int           vn = 0;
    int           rst_at = -1;
    bit           hist[64];
    int           base = 0;

    task automatic vec(input int i, input int off, input logic [L-1:0] a, input logic [L-1:0] b,
                       input logic f, input logic l);
        voff[i] = off;
        vr0[i] = a;
        vr1[i] = b;
        vf[i] = f;
        vl[i] = l;
    endtask

    task automatic play(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            en = 1'b0;
            for (int i = 0; i < vn; i++) begin
                if (voff[i] == c) begin
                    en = 1'b1;
                    r0 = vr0[i];
                    r1 = vr1[i];
                    first = vf[i];
                    last = vl[i];
                end
            end
            if (c == rst_at) rst = 1'b1;
            if (c == rst_at + 2) rst = 1'b0;
            @(posedge clk);
            #1;
            if (c == 0) base = cyc;
            @(negedge clk);
            hist[c] = busy;
        end
        en = 1'b0;
    endtask

    task automatic clear_run();
        sb.delete();
        dvq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        logic [L-1:0] one, ones, v;
        int lows;
        one = 1;
        ones = '1;

        repeat (3) @(negedge clk);
        chk("rst_digit_out", L'(digit_out), '0);
        chk("rst_digit_valid", L'(digit_valid), '0);
        chk("rst_acc_out", acc_out, '0);
        chk("rst_done", L'(done), '0);
        chk("rst_busy", L'(busy), '0);
        chk("rst_drop_err", L'(drop_err), '0);
        chk("rst_ovf_err", L'(ovf_err), '0);
        rst = 1'b0;
        @(negedge clk);

        clear_run();
        vn = 1;
        vec(0, 0, L'(1), L'(2), 1'b1, 1'b1);
        push(L'(3), 1'b1, '0);
        play(14);
        chk("t1_drained", L'(sb.size()), '0);
        chk("t1_latency", L'(dvq.size() == 1 ? dvq[0] - base : 0), L'(9));

        clear_run();
        v = ones >> 1;
        vec(0, 0, v, L'(1), 1'b1, 1'b1);
        push('0, 1'b1, one << (L - 1 - RADIX));
        play(14);
        chk("t2_drained", L'(sb.size()), '0);
        chk("t2_ovf_err", L'(ovf_err), '0);

        clear_run();
        vn = 3;
        v = (one << RADIX) + L'(5);
        vec(0, 0, v, '0, 1'b1, 1'b0);
        vec(1, 12, v, '0, 1'b0, 1'b0);
        vec(2, 24, v, '0, 1'b0, 1'b1);
        push(L'(5), 1'b0, '0);
        push(L'(6), 1'b0, '0);
        push(L'(6), 1'b1, L'(1));
        play(40);
        chk("t3_drained", L'(sb.size()), '0);
        chk("t3_digit_count", L'(dvq.size()), L'(3));

        clear_run();
        vn = 2;
        vec(0, 0, L'(7), '0, 1'b1, 1'b1);
        vec(1, 5, L'(9), L'(1), 1'b1, 1'b1);
        push(L'(7), 1'b1, '0);
        push(L'(10), 1'b1, '0);
        play(24);
        lows = 0;
        for (int c = 0; c < 18; c++) if (!hist[c]) lows++;
        chk("t4_drained", L'(sb.size()), '0);
        chk("t4_first_time", L'(dvq.size() == 2 ? dvq[0] - base : 0), L'(9));
        chk("t4_second_time", L'(dvq.size() == 2 ? dvq[1] - base : 0), L'(18));
        chk("t4_busy_gaps", L'(lows), '0);
        chk("t4_idle_after", L'(hist[19]), '0);
        chk("t4_drop_err", L'(drop_err), '0);

        clear_run();
        vn = 3;
        vec(0, 0, L'(11), '0, 1'b1, 1'b1);
        vec(1, 3, L'(12), '0, 1'b1, 1'b1);
        vec(2, 6, L'(13), '0, 1'b1, 1'b1);
        push(L'(11), 1'b1, '0);
        push(L'(12), 1'b1, '0);
        play(30);
        chk("t5_drained", L'(sb.size()), '0);
        chk("t5_digit_count", L'(dvq.size()), L'(2));
        chk("t5_drop_err", L'(drop_err), L'(1));

        clear_run();
        vn = 1;
        vec(0, 0, ones, ones, 1'b1, 1'b1);
        push((one << RADIX) - L'(2), 1'b1, ones >> RADIX);
        play(12);
        chk("t6_drained", L'(sb.size()), '0);
        chk("t6_ovf_err", L'(ovf_err), L'(1));
        chk("t6_drop_err_sticky", L'(drop_err), L'(1));

        clear_run();
        vec(0, 0, L'(5), '0, 1'b1, 1'b1);
        rst_at = 4;
        play(25);
        rst_at = -1;
        chk("t7_no_digit", L'(dvq.size()), '0);
        chk("t7_digit_out", L'(digit_out), '0);
        chk("t7_acc_out", acc_out, '0);
        chk("t7_done", L'(done), '0);
        chk("t7_busy", L'(busy), '0);
        chk("t7_drop_err", L'(drop_err), '0);
        chk("t7_ovf_err", L'(ovf_err), '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/carry_acc_stage.md
# carry_acc_stage

Word-serial accumulator that sits directly downstream of the inner multiply loop. It consumes each redundant partial-product pair (r0, r1) that the loop emits, and adds the pair plus the running accumulator chunk-by-chunk with a propagated carry. Each iteration it retires one radix-wide product digit (LSB first) and shifts the accumulator right by radix. After the last iteration it presents the remaining high part of the product.

## Interface
- Size, 3072, operand width; the inner loop's a input is Size+2 bits.
- radix, 78, digit width; one digit is retired per iteration.
- W, 394, chunk width of the adder datapath.
- NCH, (Size+radix+2)/W = 8, number of chunks; derived, not overridable.
- L, Size+radix+2 = 3152, accumulator and input width; derived.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  one-cycle strobe: r0/r1/first/last valid (driven from the inner loop's en_out).
- r0  in  L  low-half partial products.
- r1  in  L  high-half partial products, already radix-shifted.
- first  in  1  with en: treat accumulator as zero for this iteration.
- last  in  1  with en: this iteration ends the multiplication.
- digit_out  out  radix  retired product digit.
- digit_valid  out  1  one-cycle strobe for digit_out.
- acc_out  out  L  high part of product after the last iteration; holds until the next done.
- done  out  1  one-cycle strobe, coincident with the final digit_valid.
- busy  out  1  high in ADD or SHIFT.
- drop_err  out  1  sticky: an en was lost.
- ovf_err  out  1  sticky: nonzero carry out of the top chunk.

## Operation
- Capture regs: cr0, cr1, cfirst, clast.
- One-deep pending buffer: pr0, pr1, pfirst, plast, pvalid.
- en while IDLE and pvalid=0: load the capture regs and go to ADD (k=0, carry=0).
- en while busy and pvalid=0: load the pending buffer and set pvalid.
- en while busy and pvalid=1: discard the strobe and set drop_err. Capture regs and pending buffer are unchanged.
- FSM states: IDLE, ADD, SHIFT.
- ADD, chunk k = 0..NCH-1, one per cycle:
  - s = acc[k*W+:W] (forced to 0 if cfirst) + cr0[k*W+:W] + cr1[k*W+:W] + carry; s is W+2 bits.
  - sum[k*W+:W] <= s[W-1:0]; carry <= s[W+1:W].
  - At k = NCH-1, go to SHIFT. A nonzero final carry sets ovf_err; the carry is discarded.
- SHIFT, one cycle:
  - digit_out <= sum[radix-1:0]; digit_valid <= 1.
  - acc <= sum >> radix, zero-filled.
  - If clast: acc_out <= sum >> radix, done <= 1, acc <= 0.
  - Next state: if pvalid, move pending into the capture regs, clear pvalid, go to ADD with k=0. Otherwise go to IDLE.
- An en arriving in the same cycle as the SHIFT that drains the pending buffer is accepted into the pending buffer. Drain and refill occur together and no drop is flagged.
- Width rule: for legal inputs (a < 2^(Size+2), bi < 2^radix), acc + r0 + r1 < 2^L, so ovf_err stays 0.

## Timing
- Reset (asynchronous, active-high):
  - State returns to IDLE; k, carry, acc, sum, the capture regs, the pending buffer and pvalid clear to 0.
  - digit_out=0, digit_valid=0, acc_out=0, done=0, busy=0, drop_err=0, ovf_err=0.
- Reset mid-operation aborts the iteration. No digit_valid follows.
- Latency: en sampled at edge E0; ADD occupies edges E1..E8; SHIFT at E9. digit_valid and done are high for the cycle after E9, giving 9 cycles.
- Throughput: one iteration per NCH+1 = 9 cycles.
- The inner loop issues en every 5 cycles. The pending buffer absorbs at most one early strobe. Upstream must pace en at ≥9 cycles sustained.
- busy rises the cycle after an accepted en. It stays high through a back-to-back pending start with no IDLE gap.
- drop_err and ovf_err clear only on rst.

## Test plan
- Single iteration: first=last=1, r0=1, r1=2 -> 9 cycles later digit_out=3, digit_valid=1, done=1, acc_out=0.
- Full carry chain: first=last=1, r0=2^(L-1)-1, r1=1 -> sum=2^(L-1); digit_out=0; acc_out=2^(L-1-radix); ovf_err=0.
- Three iterations: en every 12 cycles, first on #1, last on #3, each with r0=2^radix+5, r1=0.
  - Digits 5, 6, 6.
  - done only with the third digit; acc_out=1.
- Back-to-back: en at cycles 0 and 5 -> second en held in pending; digit_valid at cycles 9 and 18; busy continuous; drop_err=0.
- Drop: en at cycles 0, 3 and 6 -> en at cycle 6 is dropped and drop_err=1 stays set; exactly two digit_valid pulses.
- Overflow and reset: r0=r1=2^L-1 with first=1 -> ovf_err=1 after SHIFT. Then assert rst at E4 of the next iteration -> all outputs 0 and no digit_valid.
